clock_synthesizer_multi: RTL and testbench
==========================================

Name: clock_synthesizer_multi

Overview:
- Parametrised successor to the single fixed 50 MHz divider.
- Generates NUM_CH independent square-wave clocks from input_clock, each with these runtime-programmable settings: half-period, start phase and enable.
- Supports glitch-free stop, shadowed reconfiguration and a global re-align pulse.
- Drives ADC-side clocks and the slow status/heartbeat clocks in the ADS131A0X front end.

Parameters:
- NUM_CH, 2, number of output clock channels (1..8).
- CNT_W, 32, width of the half-period, phase and counter registers.
- DEFAULT_HALF, 12_499_999, half-period loaded into every channel at reset. A channel toggles every DEFAULT_HALF+1 input cycles, which gives 2 Hz at 50 MHz.

Ports:
- input_clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel run enable, level-sensitive.
- cfg_we  in  1  one-cycle configuration write strobe.
- cfg_ch  in  3  channel index for the write. Writes with cfg_ch >= NUM_CH are ignored.
- cfg_half  in  CNT_W  new half-period H. Output toggles when the counter equals H.
- cfg_phase  in  CNT_W  counter start value used on IDLE->RUN and on sync.
- sync  in  1  one-cycle pulse that re-aligns all active channels.
- clk_out  out  NUM_CH  generated clocks, registered.
- rise_tick  out  NUM_CH  1-cycle pulse, high in the same cycle clk_out[i] first reads 1.
- fall_tick  out  NUM_CH  1-cycle pulse, high in the same cycle clk_out[i] first reads 0.
- running  out  NUM_CH  1 when the channel state is not IDLE.

Behaviour:
- Reset (priority 1):
  - All outputs go to 0: clk_out, rise_tick, fall_tick, running.
  - Every channel enters IDLE with cnt=0 and phase=0.
  - half_active = half_pending = DEFAULT_HALF.
- Per-channel states are IDLE, RUN and STOP. All registers update on posedge input_clock.
- IDLE:
  - clk_out=0 and cnt=0.
  - If ch_en[i]=1, go to RUN next cycle with cnt <= min(phase, half_active). clk_out stays 0.
- RUN and STOP counting:
  - If cnt == half_active: cnt <= 0, clk_out toggles, and the matching tick fires.
  - Otherwise cnt <= cnt+1.
  - Period is 2*(H+1) input cycles. H=0 gives divide-by-2 with 50% duty.
- Leaving RUN:
  - ch_en[i]=0 while clk_out=0: go to IDLE next cycle, cnt <= 0.
  - ch_en[i]=0 while clk_out=1: go to STOP.
  - STOP keeps counting until the falling toggle, then goes to IDLE. No truncated high pulse is ever produced.
  - ch_en[i]=1 again during STOP: return to RUN with no disturbance to cnt or clk_out.
- Configuration write (cfg_we=1, valid cfg_ch):
  - half_pending[cfg_ch] <= cfg_half and phase[cfg_ch] <= cfg_phase.
  - In IDLE, half_active is also loaded in the same cycle.
  - In RUN or STOP, half_active <= half_pending only on a falling toggle, so each full period uses one H value.
  - A write that coincides with a falling toggle is applied at the following falling toggle. The toggle uses the pre-write pending value.
- Shrinking H mid-period: cannot strand the counter, because the new value applies only when cnt resets to 0.
- Mid-STOP write: a STOP->IDLE transition is a falling toggle, so the pending value is applied on entry to IDLE.
- sync (priority 2, above enable and counting), for every channel in RUN or STOP:
  - cnt <= min(phase, half_active) and clk_out <= 0.
  - fall_tick fires if clk_out was 1; the high pulse may be truncated, and this is allowed.
  - half_active <= half_pending.
  - STOP channels go to IDLE.
  - IDLE channels are unaffected.
  - If ch_en rises in the same cycle as sync, the normal IDLE->RUN entry applies.
- Counter arithmetic: unsigned CNT_W bits. No wrap is possible because cnt never exceeds half_active. H = 2^CNT_W-1 is legal.
- Channels are fully independent except for the shared cfg and sync ports.

Test Plan:
- Reset, ch_en=01, default H -> ch0 rises after 12_500_000 cycles and has period 25_000_000. ch1 stays 0 with running[1]=0.
- Write ch0 H=0 and phase=0 while IDLE, then enable -> clk_out[0] toggles every cycle. rise_tick and fall_tick alternate every cycle.
- ch1 H=4 running, write H=9 mid-high-phase -> the current period completes at 10 cycles. From that falling edge the period is 20 cycles, with the tick spacing checked.
- ch0 H=5, drop ch_en while clk_out=1 at cnt=2 -> stays high 3 more cycles, then falls with fall_tick, then running=0. Re-raising ch_en during STOP keeps cadence unchanged.
- Both channels H=7, ch1 phase=4, enable together -> ch0 first rise at cycle 8, ch1 at cycle 4. sync pulse -> both forced low and re-aligned with the same offsets.
- cfg_we with cfg_ch=5 (NUM_CH=2) -> no register changes. Reset asserted mid-run -> all outputs 0 the next cycle and H=DEFAULT_HALF.

Source files
------------

// File: rtl/clock_synthesizer_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent square waves from input_clock,
// each with shadowed half-period, start phase, glitch-free stop and a shared re-align pulse.
module clock_synthesizer_multi #(
  parameter int unsigned      NUM_CH       = 2,
  parameter int unsigned      CNT_W        = 32,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(12_499_999)
) (
  input  logic              input_clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_tick,
  output logic [NUM_CH-1:0] fall_tick,
  output logic [NUM_CH-1:0] running
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

  function automatic logic [CNT_W-1:0] min_u(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_act_q, half_act_d;
    logic [CNT_W-1:0] half_pend_q, phase_q;
    logic             clk_q, clk_d, rise_q, rise_d, fall_q, fall_d;
    logic             cfg_hit, at_top;

    assign cfg_hit = cfg_we && (cfg_ch == 3'(i));
    assign at_top  = (cnt_q == half_act_q);

    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      half_act_d = half_act_q;
      clk_d      = clk_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      if (sync && state_q != IDLE) begin
        // Seed from the newly adopted H so the counter can never start above it.
        half_act_d = half_pend_q;
        clk_d      = 1'b0;
        fall_d     = clk_q;
        if (state_q == STOP) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = min_u(phase_q, half_pend_q);
        end
      end else begin
        case (state_q)
          IDLE: begin
            clk_d = 1'b0;
            cnt_d = '0;
            if (cfg_hit) half_act_d = cfg_half;
            if (ch_en[i]) begin
              state_d = RUN;
              cnt_d   = min_u(cfg_hit ? cfg_phase : phase_q, half_act_d);
            end
          end
          RUN, STOP: begin
            if (state_q == RUN && !ch_en[i] && !clk_q) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              if (at_top) begin
                cnt_d  = '0;
                clk_d  = !clk_q;
                rise_d = !clk_q;
                fall_d = clk_q;
                if (clk_q) half_act_d = half_pend_q;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
              // Only reachable with clk high when disabled: drain until the falling toggle.
              if (ch_en[i])    state_d = RUN;
              else if (at_top) state_d = IDLE;
              else             state_d = STOP;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
            clk_d   = 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge input_clock) begin
      if (reset) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        half_act_q  <= DEFAULT_HALF;
        half_pend_q <= DEFAULT_HALF;
        phase_q     <= '0;
        clk_q       <= 1'b0;
        rise_q      <= 1'b0;
        fall_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        half_act_q <= half_act_d;
        clk_q      <= clk_d;
        rise_q     <= rise_d;
        fall_q     <= fall_d;
        if (cfg_hit) begin
          half_pend_q <= cfg_half;
          phase_q     <= cfg_phase;
        end
      end
    end

    assign clk_out[i]   = clk_q;
    assign rise_tick[i] = rise_q;
    assign fall_tick[i] = fall_q;
    assign running[i]   = (state_q != IDLE);
  end

endmodule

// File: tb/tb_clock_synthesizer_multi.sv
// Bench for clock_synthesizer_multi: directed scenarios plus random traffic, every cycle
// compared against a level/position reference model of each channel.
module tb_clock_synthesizer_multi;
  localparam int NCH = 2;
  localparam int W   = 16;
  localparam int DEF = 20;

  logic             input_clock = 1'b0;
  logic             reset = 1'b1;
  logic [NCH-1:0]   ch_en = '0;
  logic             cfg_we = 1'b0;
  logic [2:0]       cfg_ch = '0;
  logic [W-1:0]     cfg_half = '0;
  logic [W-1:0]     cfg_phase = '0;
  logic             sync = 1'b0;
  logic [NCH-1:0]   clk_out, rise_tick, fall_tick, running;

  int checks = 0;
  int errors = 0;

  clock_synthesizer_multi #(.NUM_CH(NCH), .CNT_W(W), .DEFAULT_HALF(W'(DEF))) dut (
    .input_clock(input_clock), .reset(reset), .ch_en(ch_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .cfg_phase(cfg_phase), .sync(sync), .clk_out(clk_out),
    .rise_tick(rise_tick), .fall_tick(fall_tick), .running(running));

  always #5 input_clock = ~input_clock;

  // Model: level, position within the current half-period, active/draining flags.
  int m_pos[NCH], m_h[NCH], m_hp[NCH], m_ph[NCH];
  bit m_on[NCH], m_drain[NCH], m_lvl[NCH], m_rise[NCH], m_fall[NCH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int umin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step();
    bit wr, en, fell;
    for (int c = 0; c < NCH; c++) begin
      wr = cfg_we && (int'(cfg_ch) == c);
      en = ch_en[c];
      fell = 0;
      m_rise[c] = 0;
      m_fall[c] = 0;
      if (reset) begin
        m_on[c] = 0; m_drain[c] = 0; m_lvl[c] = 0; m_pos[c] = 0;
        m_h[c] = DEF; m_hp[c] = DEF; m_ph[c] = 0;
        continue;
      end
      if (sync && m_on[c]) begin
        m_fall[c] = m_lvl[c];
        m_lvl[c] = 0;
        m_h[c] = m_hp[c];
        if (m_drain[c]) begin m_on[c] = 0; m_drain[c] = 0; m_pos[c] = 0; end
        else m_pos[c] = umin(m_ph[c], m_h[c]);
      end else if (!m_on[c]) begin
        if (wr) m_h[c] = int'(cfg_half);
        if (en) begin
          m_on[c] = 1;
          m_pos[c] = umin(wr ? int'(cfg_phase) : m_ph[c], m_h[c]);
        end
      end else if (!en && !m_lvl[c]) begin
        m_on[c] = 0; m_pos[c] = 0;
      end else begin
        if (m_pos[c] == m_h[c]) begin
          m_pos[c] = 0;
          if (m_lvl[c]) begin fell = 1; m_fall[c] = 1; m_h[c] = m_hp[c]; end
          else m_rise[c] = 1;
          m_lvl[c] = !m_lvl[c];
        end else m_pos[c]++;
        if (en) m_drain[c] = 0;
        else if (fell) begin m_on[c] = 0; m_drain[c] = 0; end
        else m_drain[c] = 1;
      end
      if (wr) begin m_hp[c] = int'(cfg_half); m_ph[c] = int'(cfg_phase); end
    end
  endtask

  task automatic cycle();
    logic [NCH-1:0] e_clk, e_r, e_f, e_run;
    model_step();
    @(posedge input_clock);
    #1;
    for (int c = 0; c < NCH; c++) begin
      e_clk[c] = m_lvl[c]; e_r[c] = m_rise[c]; e_f[c] = m_fall[c]; e_run[c] = m_on[c];
    end
    chk("clk_out", 32'(clk_out), 32'(e_clk));
    chk("rise_tick", 32'(rise_tick), 32'(e_r));
    chk("fall_tick", 32'(fall_tick), 32'(e_f));
    chk("running", 32'(running), 32'(e_run));
  endtask

  task automatic do_reset();
    ch_en = '0; reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
  endtask

  task automatic cfg_wr(input int c, input int h, input int ph);
    cfg_we = 1'b1; cfg_ch = 3'(c); cfg_half = W'(h); cfg_phase = W'(ph);
    cycle();
    cfg_we = 1'b0;
  endtask

  // Cycles until the chosen tick on channel c fires; 200 means it never came.
  task automatic wait_tick(input bit rise, input int c, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(rise ? rise_tick[c] : fall_tick[c]) && n < 200);
  endtask

  initial begin
    int n, r0, r1, r;
    do_reset();
    chk("rst_outs", 32'({clk_out, rise_tick, fall_tick, running}), 32'd0);

    // Default H: first rise DEF+1 cycles after entering RUN, period 2*(DEF+1)
    ch_en = 2'b01; cycle();
    chk("run0_on", 32'(running[0]), 32'd1);
    wait_tick(1, 0, n); chk("dflt_first_rise", n, DEF + 1);
    wait_tick(1, 0, n); chk("dflt_period", n, 2 * (DEF + 1));
    chk("ch1_idle", 32'({running[1], clk_out[1]}), 32'd0);

    // H=0: divide by 2, ticks alternate
    do_reset();
    cfg_wr(0, 0, 0);
    ch_en = 2'b01; cycle();
    for (int j = 0; j < 6; j++) begin
      cycle();
      chk("div2_clk", 32'(clk_out[0]), 32'(j % 2 == 0));
      chk("div2_rise", 32'(rise_tick[0]), 32'(j % 2 == 0));
      chk("div2_fall", 32'(fall_tick[0]), 32'(j % 2 == 1));
    end

    // Shadowed H change mid-high-phase
    do_reset();
    cfg_wr(1, 4, 0);
    ch_en = 2'b10; cycle();
    wait_tick(1, 1, n); chk("h4_first_rise", n, 5);
    cycle(); cycle();
    cfg_wr(1, 9, 0);
    wait_tick(0, 1, n); chk("h4_high_len", n + 3, 5);
    wait_tick(1, 1, n); chk("h9_low_len", n, 10);
    wait_tick(0, 1, n); chk("h9_high_len", n, 10);

    // Glitch-free stop, then resume during STOP
    do_reset();
    cfg_wr(0, 5, 0);
    ch_en = 2'b01; cycle();
    wait_tick(1, 0, n); chk("h5_first_rise", n, 6);
    cycle(); cycle();
    ch_en = 2'b00;
    wait_tick(0, 0, n); chk("stop_drain", n, 4);
    chk("stop_idle", 32'(running[0]), 32'd0);
    ch_en = 2'b01; cycle();
    wait_tick(1, 0, n); chk("restart_rise", n, 6);
    cycle();
    ch_en = 2'b00; cycle();
    ch_en = 2'b01;
    wait_tick(0, 0, n); chk("resume_fall", n + 2, 6);
    wait_tick(1, 0, n); chk("resume_rise", n, 6);
    chk("resume_run", 32'(running[0]), 32'd1);

    // Phase offsets and sync re-align
    do_reset();
    cfg_wr(0, 7, 0);
    cfg_wr(1, 7, 4);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) ch_en = 2'b11;
      else sync = 1'b1;
      cycle();
      sync = 1'b0;
      if (pass == 1) chk("sync_low", 32'(clk_out), 32'd0);
      r0 = 0; r1 = 0;
      for (int k = 1; k <= 20; k++) begin
        cycle();
        if (rise_tick[0] && r0 == 0) r0 = k;
        if (rise_tick[1] && r1 == 0) r1 = k;
      end
      chk("ph_rise0", r0, 8);
      chk("ph_rise1", r1, 4);
    end

    // Out-of-range channel write ignored, then reset mid-run
    cfg_wr(5, 0, 0);
    wait_tick(1, 0, n);
    wait_tick(1, 0, n); chk("cfg_ch5_ignored", n, 16);
    reset = 1'b1; cycle(); reset = 1'b0;
    chk("midrun_rst", 32'({clk_out, rise_tick, fall_tick, running}), 32'd0);
    ch_en = 2'b01; cycle();
    wait_tick(1, 0, n); chk("rst_dflt_h", n, DEF + 1);

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      r = $urandom_range(0, 99);
      if (r < 8) ch_en = 2'($urandom);
      cfg_we = (r >= 8 && r < 16);
      cfg_ch = 3'($urandom_range(0, 4));
      cfg_half = W'($urandom_range(0, 6));
      cfg_phase = W'($urandom_range(0, 8));
      sync = (r == 50 || r == 51);
      reset = (r == 99 && (k % 5 == 0));
      cycle();
    end
    cfg_we = 1'b0; sync = 1'b0; reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
